prog_loader: RTL and testbench

- Writer side of the instruction store: accepts a byte stream over a valid/ready handshake and packs it into 16-bit instruction words.
- Writes each word into program memory at sequential addresses. The fetch/decode sequencer later reads these words by pc.
- Checks the opcode field of every word as it is written.
- Terminates on HLT or at the end of the address space, then reports done, word count and first-error address.

---
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Instruction-store writer: packs a byte stream into 16-bit words, writes them to
// program memory at sequential addresses, checks opcodes and stops on HLT or the last address.
module prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int STOP_ON_HLT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_data,
  output logic                mem_wr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [3:0]        OP_HLT     = 4'b1100;
  localparam logic [3:0]        OP_ILLEGAL = 4'b0110;

  typedef enum logic [2:0] {
    IDLE,
    GET_HI,
    GET_LO,
    WRITE,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          hi_reg, hi_next;
  logic [15:0]         data_reg, data_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                err_reg, err_next;
  logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;

  logic                xfer;
  logic                is_hlt;
  logic                is_illegal;

  // byte_ready is a pure state decode so the source never sees a combinational loop
  assign byte_ready = (state_reg == GET_HI) || (state_reg == GET_LO);
  assign xfer       = byte_valid && byte_ready;
  assign is_hlt     = (STOP_ON_HLT != 0) && (data_reg[15:12] == OP_HLT);
  assign is_illegal = (data_reg[15:12] == OP_ILLEGAL);

  always_comb begin
    state_next    = state_reg;
    hi_next       = hi_reg;
    data_next     = data_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    err_next      = err_reg;
    err_addr_next = err_addr_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next    = GET_HI;
          addr_next     = FIRST_ADDR;
          count_next    = '0;
          err_next      = 1'b0;
          err_addr_next = '0;
        end
      end
      GET_HI: begin
        if (xfer) begin
          hi_next    = byte_in;
          state_next = GET_LO;
        end
      end
      GET_LO: begin
        if (xfer) begin
          data_next  = {hi_reg, byte_in};
          state_next = WRITE;
        end
      end
      WRITE: begin
        count_next = count_reg + (ADDR_W+1)'(1);
        // Only the first illegal word is located; the word is still written
        if (is_illegal && !err_reg) begin
          err_next      = 1'b1;
          err_addr_next = addr_reg;
        end
        if (is_hlt || (addr_reg == LAST_ADDR)) begin
          state_next = DONE;
        end else begin
          addr_next  = addr_reg + ADDR_W'(1);
          state_next = GET_HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hi_reg       <= '0;
      data_reg     <= '0;
      addr_reg     <= '0;
      count_reg    <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hi_reg       <= hi_next;
      data_reg     <= data_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign mem_wr     = (state_reg == WRITE);
  assign busy       = (state_reg == GET_HI) || (state_reg == GET_LO) || (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  assign mem_addr   = addr_reg;
  assign mem_data   = data_reg;
  assign err        = err_reg;
  assign err_addr   = err_addr_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default instance for HLT/error/reset cases,
// a second instance with STOP_ON_HLT=0 for the full-depth load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic        byte_ready, mem_wr, busy, done, err;
  logic [7:0]  mem_addr, err_addr;
  logic [15:0] mem_data;
  logic [8:0]  word_count;

  logic        byte_ready2, mem_wr2, busy2, done2, err2;
  logic [7:0]  mem_addr2, err_addr2;
  logic [15:0] mem_data2;
  logic [8:0]  word_count2;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .word_count(word_count)
  );

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0), .STOP_ON_HLT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready2), .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_wr(mem_wr2),
    .busy(busy2), .done(done2), .err(err2), .err_addr(err_addr2), .word_count(word_count2)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          sel = 1'b0;
  logic        cur_ready, cur_wr, cur_done;
  logic [7:0]  cur_addr;
  logic [15:0] cur_data;
  assign cur_ready = sel ? byte_ready2 : byte_ready;
  assign cur_wr    = sel ? mem_wr2 : mem_wr;
  assign cur_done  = sel ? done2 : done;
  assign cur_addr  = sel ? mem_addr2 : mem_addr;
  assign cur_data  = sel ? mem_data2 : mem_data;

  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          ready_viol = 0;
  int          zero_writes = 0;

  always @(negedge clk) begin
    if (!rst && cur_wr) begin
      wr_addr_q.push_back(cur_addr);
      wr_data_q.push_back(cur_data);
      if (cur_ready) ready_viol++;
      if (cur_addr == 8'd0) zero_writes++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int first_cyc;
  bit arm_first;

  task automatic send_byte(input logic [7:0] b);
    bit got;
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    got = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      got = cur_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    byte_valid = 1'b0;
    if (!got) check("byte_accept_timeout", 0, 1);
    else if (arm_first) begin
      first_cyc = cyc;
      arm_first = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    if (gaps) repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
    send_byte(w[15:8]);
    if (gaps) repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!cur_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cur_done) check("done_timeout", 0, 1);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    ready_viol  = 0;
    zero_writes = 0;
  endtask

  task automatic expect_write(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_addr_q[idx]), 32'(a));
      check({tag, "_data"}, 32'(wr_data_q[idx]), 32'(d));
    end else begin
      check({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_basic_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr_q.size()), 3);
    expect_write({tag, "_w0"}, 0, 8'd0, 16'h8105);
    expect_write({tag, "_w1"}, 1, 8'd1, 16'h8203);
    expect_write({tag, "_w2"}, 2, 8'd2, 16'hC000);
  endtask

  logic [15:0] ill_words [5] = '{16'h8001, 16'h6000, 16'h7000, 16'h6F00, 16'hC000};

  initial begin
    arm_first = 1'b0;
    first_cyc = 0;

    // reset state
    #2;
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_wr",    32'(mem_wr), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(byte_ready), 0);

    // basic load, valid held high
    clear_log();
    pulse_start(1'b0);
    check("start_busy", 32'(busy), 1);
    arm_first = 1'b1;
    send_word(16'h8105, 1'b0);
    send_word(16'h8203, 1'b0);
    send_word(16'hC000, 1'b0);
    wait_done();
    check("basic_latency", 32'(cyc - first_cyc + 1), 9);
    check_basic_writes("basic");
    check("basic_done", 32'(done), 1);
    check("basic_busy", 32'(busy), 0);
    check("basic_count", 32'(word_count), 3);
    check("basic_err", 32'(err), 0);
    check("basic_hold_data", 32'(mem_data), 32'h0000C000);
    check("basic_hold_addr", 32'(mem_addr), 2);

    // gaps between bytes
    clear_log();
    pulse_start(1'b0);
    send_word(16'h8105, 1'b1);
    send_word(16'h8203, 1'b1);
    send_word(16'hC000, 1'b1);
    wait_done();
    repeat (5) begin @(posedge clk); #1; end
    check_basic_writes("gaps");
    check("gaps_ready_in_write", 32'(ready_viol), 0);
    check("gaps_count", 32'(word_count), 3);

    // illegal opcodes
    clear_log();
    pulse_start(1'b0);
    foreach (ill_words[i]) send_word(ill_words[i], 1'b0);
    wait_done();
    check("ill_nwr", 32'(wr_addr_q.size()), 5);
    foreach (ill_words[i]) expect_write("ill", i, 8'(i), ill_words[i]);
    check("ill_err", 32'(err), 1);
    check("ill_err_addr", 32'(err_addr), 1);
    check("ill_count", 32'(word_count), 5);

    // full depth, no HLT stop
    sel = 1'b1;
    clear_log();
    pulse_start(1'b1);
    for (int i = 0; i < 256; i++) send_word((i == 10) ? 16'hC000 : 16'h0000, 1'b0);
    wait_done();
    repeat (5) begin @(posedge clk); #1; end
    check("full_nwr", 32'(wr_addr_q.size()), 256);
    expect_write("full_hlt", 10, 8'd10, 16'hC000);
    expect_write("full_last", 255, 8'd255, 16'h0000);
    check("full_done", 32'(done2), 1);
    check("full_count", 32'(word_count2), 256);
    check("full_addr0_writes", 32'(zero_writes), 1);
    check("full_ready_after", 32'(byte_ready2), 0);
    sel = 1'b0;

    // reset mid-word
    clear_log();
    pulse_start(1'b0);
    send_byte(8'h81);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(byte_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_data", 32'(mem_data), 0);
    check("arst_count", 32'(word_count), 0);
    check("arst_err", 32'(err), 0);
    check("arst_err_addr", 32'(err_addr), 0);
    check("arst_full_count", 32'(word_count2), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
    pulse_start(1'b0);
    send_word(16'h8203, 1'b0);
    send_word(16'hC000, 1'b0);
    wait_done();
    check("arst_nwr", 32'(wr_addr_q.size()), 2);
    expect_write("arst_w0", 0, 8'd0, 16'h8203);

    // start while busy, then restart after done
    clear_log();
    pulse_start(1'b0);
    send_word(16'h8105, 1'b0);
    send_byte(8'h62);
    pulse_start(1'b0);
    send_byte(8'h03);
    send_word(16'hC000, 1'b0);
    wait_done();
    check("sb_nwr", 32'(wr_addr_q.size()), 3);
    expect_write("sb_w0", 0, 8'd0, 16'h8105);
    expect_write("sb_w1", 1, 8'd1, 16'h6203);
    expect_write("sb_w2", 2, 8'd2, 16'hC000);
    check("sb_err", 32'(err), 1);
    check("sb_err_addr", 32'(err_addr), 1);
    clear_log();
    pulse_start(1'b0);
    check("restart_done", 32'(done), 0);
    check("restart_err", 32'(err), 0);
    check("restart_count", 32'(word_count), 0);
    check("restart_addr", 32'(mem_addr), 0);
    send_word(16'hC000, 1'b0);
    wait_done();
    check("restart_nwr", 32'(wr_addr_q.size()), 1);
    expect_write("restart_w0", 0, 8'd0, 16'hC000);
    check("restart_final_count", 32'(word_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
